// File: rtl/prog_loader.sv
// Byte-serial program loader: frames a 16-bit word count, assembles big-endian words,
// writes them to program memory and holds the CPU in reset until the image is complete.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   IDX_ONE   = 1;

   state_t            state_reg;
   logic [ADDR_W:0]   idx_reg;
   logic [15:0]       len_reg;
   logic [7:0]        hi_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        csum_reg;
`endif

   logic              xfer;
   logic [15:0]       len_word;
   logic              len_bad;
   logic [16:0]       idx_inc_ext;
   logic              last_word;

   always_comb begin
      byte_ready = 1'b0;
      case (state_reg)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: byte_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHECK:                                  byte_ready = 1'b1;
`endif
         default:                                  byte_ready = 1'b0;
      endcase
   end

   assign xfer        = byte_valid & byte_ready;
   assign len_word    = {hi_reg, byte_in};
   assign len_bad     = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);
   // Index is one bit wider than the address so a full 2^ADDR_W image ends without wrapping.
   assign idx_inc_ext = 17'(idx_reg) + 17'd1;
   assign last_word   = (idx_inc_ext == {1'b0, len_reg});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         len_reg   <= '0;
         hi_reg    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_reg  <= '0;
`endif
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg <= S_LEN_HI;
                  idx_reg   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_reg  <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  hi_reg    <= byte_in;
                  state_reg <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  len_reg <= len_word;
                  if (len_bad) begin
                     state_reg <= S_ERR;
                     error     <= 1'b1;
                  end else begin
                     state_reg <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (xfer) begin
                  hi_reg    <= byte_in;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_reg  <= csum_reg ^ byte_in;
`endif
                  state_reg <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx_reg[ADDR_W-1:0];
                  mem_wdata <= {hi_reg, byte_in};
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_reg  <= csum_reg ^ byte_in;
`endif
                  state_reg <= S_WRITE;
               end
            end
            S_WRITE: begin
               idx_reg <= idx_reg + IDX_ONE;
               if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_reg <= S_CHECK;
`else
                  state_reg <= S_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
`endif
               end else begin
                  state_reg <= S_DATA_HI;
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (xfer) begin
                  if (byte_in == csum_reg) begin
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state_reg <= S_ERR;
                     error     <= 1'b1;
                  end
               end
            end
`endif
            S_DONE, S_ERR: begin
               if (start) begin
                  state_reg <= S_LEN_HI;
                  idx_reg   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_reg  <= '0;
`endif
                  done      <= 1'b0;
                  error     <= 1'b0;
                  cpu_reset <= 1'b1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load scenarios plus reset-mid-load sequence,
// checked against a word-list/XOR model of the loader behaviour.
module tb_prog_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;
   wr_t wr_q[$];

   typedef struct {
      int n;
      int mode;      // 0 fixed test words, 1 random words
      int gap;       // 0 full rate, 1 random idle cycles
      bit corrupt;
      bit exp_done;
      bit exp_err;
      int exp_writes;
   } vec_t;

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_we) wr_q.push_back({mem_addr, mem_wdata});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = b;
      waited     = 0;
      while (!byte_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) begin
         errors++;
         checks++;
         $display("FAIL byte_timeout byte %0h not accepted after %0d cycles", b, waited);
      end
      @(posedge clk);
   endtask

   task automatic do_start();
      @(negedge clk);
      start      = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("start_cpu_reset", cpu_reset, 1);
      chk("start_done", done, 0);
      chk("start_error", error, 0);
      chk("start_ready", byte_ready, 1);
   endtask

   task automatic run_case(input vec_t v, input int id);
      logic [15:0] words[$];
      logic [15:0] nh;
      logic [7:0]  xsum;
      int          g;
      int          mism;
      words.delete();
      for (int i = 0; i < v.exp_writes; i++)
         words.push_back(v.mode == 0 ? (i == 0 ? 16'h80F1 : i == 1 ? 16'h8012 : 16'h2123)
                                     : 16'($urandom));
      wr_q.delete();
      xsum = 8'h00;
      nh   = 16'(v.n);
      do_start();
      send_byte(nh[15:8], 0);
      send_byte(nh[7:0], 0);
      if (v.exp_writes == 0) begin
         @(negedge clk);
         byte_valid = 1'b0;
         chk("hdr_error", error, v.exp_err);
         chk("hdr_done", done, v.exp_done);
         chk("hdr_cpu_reset", cpu_reset, 1);
         chk("hdr_ready", byte_ready, 0);
      end else begin
         foreach (words[i]) begin
            g = (v.gap != 0) ? $urandom_range(0, 2) : 0;
            send_byte(words[i][15:8], g);
            g = (v.gap != 0) ? $urandom_range(0, 2) : 0;
            send_byte(words[i][7:0], g);
            xsum = xsum ^ words[i][15:8] ^ words[i][7:0];
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         send_byte(v.corrupt ? (xsum ^ 8'h5A) : xsum, 0);
         @(negedge clk);
         byte_valid = 1'b0;
`else
         @(negedge clk);
         byte_valid = 1'b0;
         chk("last_we", mem_we, 1);
         chk("last_addr", 32'(mem_addr), 32'(v.n - 1));
         chk("last_data", mem_wdata, words[words.size()-1]);
         chk("last_not_done_yet", done, 0);
         @(negedge clk);
`endif
         chk("end_done", done, v.exp_done);
         chk("end_error", error, v.exp_err);
         chk("end_cpu_reset", cpu_reset, !v.exp_done);
      end
      chk("nwrites", wr_q.size(), v.exp_writes);
      mism = 0;
      foreach (wr_q[i])
         if (i >= words.size() || wr_q[i].addr != ADDR_W'(i) || wr_q[i].data != words[i])
            mism++;
      chk("wr_contents", mism, 0);
      // Bytes offered while finished/failed must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_in    = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      chk("idle_nwrites", wr_q.size(), v.exp_writes);
      chk("idle_done", done, v.exp_done);
      $display("case %0d n=%0d writes=%0d done=%0b error=%0b", id, v.n, wr_q.size(), done, error);
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{3,    0, 0, 0, 1, 0, 3});
      tbl.push_back('{0,    1, 0, 0, 0, 1, 0});
      tbl.push_back('{1,    1, 0, 0, 1, 0, 1});
      tbl.push_back('{1025, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{1024, 1, 0, 0, 1, 0, 1024});
      tbl.push_back('{6,    1, 1, 0, 1, 0, 6});
      tbl.push_back('{9,    1, 1, 0, 1, 0, 9});
`ifdef PROG_LOADER_CHECKSUM_EN
      tbl.push_back('{4,    1, 1, 1, 0, 1, 4});
`endif

      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", byte_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) run_case(tbl[i], i);

      // Reset asserted mid-load, right as the second word is written.
      wr_q.delete();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      @(negedge clk);
      byte_valid = 1'b0;
      chk("mid_we", mem_we, 1);
      chk("mid_addr", 32'(mem_addr), 1);
      chk("mid_data", mem_wdata, 16'h1234);
      #2 reset = 1'b0;
      #1;
      chk("arst_ready", byte_ready, 0);
      chk("arst_we", mem_we, 0);
      chk("arst_addr", 32'(mem_addr), 0);
      chk("arst_wdata", mem_wdata, 0);
      chk("arst_cpu_reset", cpu_reset, 1);
      chk("arst_done", done, 0);
      chk("arst_error", error, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_in    = 8'($urandom);
         chk("post_rst_ready", byte_ready, 0);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      chk("post_rst_nwrites", wr_q.size(), 2);
      $display("reset sequence writes=%0d cpu_reset=%0b", wr_q.size(), cpu_reset);

      run_case('{5, 1, 1, 0, 1, 0, 5}, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
